// File: rtl/ws2812_pkg.sv
// Shared WS2812 receive constants, timing conversion and decoder FSM states.
// No logic; no latency or backpressure of its own.
package ws2812_pkg;

  localparam int PIXEL_W             = 24;
  localparam int DEF_CLK_PERIOD_NS   = 10;
  localparam int DEF_T_BIT_THRESH_NS = 625;
  localparam int DEF_T_MIN_HIGH_NS   = 150;
  localparam int DEF_T_MAX_HIGH_NS   = 5000;
  localparam int DEF_T_LATCH_NS      = 50000;

  typedef enum logic [1:0] {
    WAIT_LATCH,
    IDLE,
    HIGH,
    LOW
  } state_t;

  function automatic int ns_to_cycles(input int ns, input int clk_period_ns);
    return ns / clk_period_ns;
  endfunction

endpackage

// File: rtl/ws2812_bit_decoder.sv
// Synchronizes DI, measures high/low widths and emits bit, latch and error events.
// Events appear 3 clk after the DI edge; no backpressure, events are single-cycle pulses.
module ws2812_bit_decoder
  import ws2812_pkg::*;
#(
  parameter int THRESH_CYC   = 62,
  parameter int MIN_HIGH_CYC = 15,
  parameter int MAX_HIGH_CYC = 500,
  parameter int LATCH_CYC    = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic di,
  output logic bit_valid,
  output logic bit_value,
  output logic latch,
  output logic glitch,
  output logic stuck,
  output logic frame_start
);

  localparam int            CW      = $clog2(LATCH_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  state_t        state_q, state_d;
  logic [CW-1:0] low_cnt_q, low_cnt_d;
  logic [CW-1:0] high_cnt_q, high_cnt_d;
  logic          bit_valid_q, bit_valid_d;
  logic          bit_value_q, bit_value_d;
  logic          latch_q, latch_d;
  logic          glitch_q, glitch_d;
  logic          stuck_q, stuck_d;
  logic          start_q, start_d;

  logic          line, rise, fall;
  logic [CW-1:0] low_inc, high_inc;

  assign line     = sync_q[1];
  assign rise     = line & ~prev_q;
  assign fall     = ~line & prev_q;
  assign low_inc  = (low_cnt_q == CNT_MAX) ? low_cnt_q : low_cnt_q + 1'b1;
  assign high_inc = (high_cnt_q == CNT_MAX) ? high_cnt_q : high_cnt_q + 1'b1;

  always_comb begin
    sync_d = {sync_q[0], di};
    prev_d = sync_q[1];
  end

  // high_cnt holds the number of high cycles seen so far, so at the falling edge it equals the pulse width
  always_comb begin
    state_d     = state_q;
    low_cnt_d   = low_cnt_q;
    high_cnt_d  = high_cnt_q;
    bit_valid_d = 1'b0;
    bit_value_d = bit_value_q;
    latch_d     = 1'b0;
    glitch_d    = 1'b0;
    stuck_d     = 1'b0;
    start_d     = 1'b0;
    case (state_q)
      WAIT_LATCH: begin
        if (line) begin
          low_cnt_d = '0;
        end else begin
          low_cnt_d = low_inc;
          if (low_inc >= CW'(LATCH_CYC)) begin
            state_d   = IDLE;
            low_cnt_d = '0;
          end
        end
      end
      IDLE: begin
        if (rise) begin
          high_cnt_d = CW'(1);
          start_d    = 1'b1;
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          low_cnt_d = CW'(1);
          if (high_cnt_q < CW'(MIN_HIGH_CYC)) begin
            glitch_d = 1'b1;
            state_d  = WAIT_LATCH;
          end else begin
            bit_valid_d = 1'b1;
            bit_value_d = (high_cnt_q >= CW'(THRESH_CYC));
            state_d     = LOW;
          end
        end else if (high_cnt_q >= CW'(MAX_HIGH_CYC)) begin
          stuck_d   = 1'b1;
          low_cnt_d = '0;
          state_d   = WAIT_LATCH;
        end else begin
          high_cnt_d = high_inc;
        end
      end
      LOW: begin
        if (rise) begin
          high_cnt_d = CW'(1);
          state_d    = HIGH;
        end else begin
          low_cnt_d = low_inc;
          if (low_inc >= CW'(LATCH_CYC)) begin
            latch_d   = 1'b1;
            low_cnt_d = '0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = WAIT_LATCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      state_q     <= WAIT_LATCH;
      low_cnt_q   <= '0;
      high_cnt_q  <= '0;
      bit_valid_q <= 1'b0;
      bit_value_q <= 1'b0;
      latch_q     <= 1'b0;
      glitch_q    <= 1'b0;
      stuck_q     <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      low_cnt_q   <= low_cnt_d;
      high_cnt_q  <= high_cnt_d;
      bit_valid_q <= bit_valid_d;
      bit_value_q <= bit_value_d;
      latch_q     <= latch_d;
      glitch_q    <= glitch_d;
      stuck_q     <= stuck_d;
      start_q     <= start_d;
    end
  end

  assign bit_valid   = bit_valid_q;
  assign bit_value   = bit_value_q;
  assign latch       = latch_q;
  assign glitch      = glitch_q;
  assign stuck       = stuck_q;
  assign frame_start = start_q;

endmodule

// File: rtl/ws2812_strip_decoder.sv
// WS2812 receiver: assembles decoded bits into pixels and publishes a strip on each latch.
// DI-to-output latency 4 clk; no backpressure, all events are single-cycle pulses.
module ws2812_strip_decoder
  import ws2812_pkg::*;
#(
  parameter int LENGTH          = 5,
  parameter int CLK_PERIOD_NS   = DEF_CLK_PERIOD_NS,
  parameter int T_BIT_THRESH_NS = DEF_T_BIT_THRESH_NS,
  parameter int T_MIN_HIGH_NS   = DEF_T_MIN_HIGH_NS,
  parameter int T_MAX_HIGH_NS   = DEF_T_MAX_HIGH_NS,
  parameter int T_LATCH_NS      = DEF_T_LATCH_NS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          DI,
  output logic [LENGTH*PIXEL_W-1:0]     strip,
  output logic [PIXEL_W-1:0]            pixel_data,
  output logic                          pixel_valid,
  output logic [$clog2(LENGTH+1)-1:0]   pixel_index,
  output logic                          receiving,
  output logic                          frame_done,
  output logic                          frame_error,
  output logic                          overflow
);

  localparam int            PW    = $clog2(LENGTH + 1);
  localparam logic [PW-1:0] LEN_C = PW'(LENGTH);

  logic bit_valid, bit_value, latch, glitch, stuck, frame_start;

  ws2812_bit_decoder #(
    .THRESH_CYC  (ns_to_cycles(T_BIT_THRESH_NS, CLK_PERIOD_NS)),
    .MIN_HIGH_CYC(ns_to_cycles(T_MIN_HIGH_NS, CLK_PERIOD_NS)),
    .MAX_HIGH_CYC(ns_to_cycles(T_MAX_HIGH_NS, CLK_PERIOD_NS)),
    .LATCH_CYC   (ns_to_cycles(T_LATCH_NS, CLK_PERIOD_NS))
  ) u_bit_decoder (
    .clk        (clk),
    .rst_n      (rst_n),
    .di         (DI),
    .bit_valid  (bit_valid),
    .bit_value  (bit_value),
    .latch      (latch),
    .glitch     (glitch),
    .stuck      (stuck),
    .frame_start(frame_start)
  );

  logic [PIXEL_W-1:0]        shift_q, shift_d;
  logic [4:0]                bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]             pix_cnt_q, pix_cnt_d;
  logic [PIXEL_W-1:0]        stage_q [LENGTH];
  logic [PIXEL_W-1:0]        stage_d [LENGTH];
  logic [LENGTH*PIXEL_W-1:0] strip_q, strip_d;
  logic [PIXEL_W-1:0]        pixel_data_q, pixel_data_d;
  logic                      pixel_valid_q, pixel_valid_d;
  logic [PW-1:0]             pixel_index_q, pixel_index_d;
  logic                      receiving_q, receiving_d;
  logic                      frame_done_q, frame_done_d;
  logic                      frame_error_q, frame_error_d;
  logic                      overflow_q, overflow_d;

  always_comb begin
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    stage_d       = stage_q;
    strip_d       = strip_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    pixel_index_d = pixel_index_q;
    receiving_d   = receiving_q;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    overflow_d    = overflow_q;

    if (frame_start) begin
      receiving_d = 1'b1;
      overflow_d  = 1'b0;
      bit_cnt_d   = '0;
      pix_cnt_d   = '0;
    end

    if (glitch || stuck) begin
      frame_error_d = 1'b1;
      receiving_d   = 1'b0;
    end else if (bit_valid) begin
      shift_d = {shift_q[PIXEL_W-2:0], bit_value};
      if (bit_cnt_q == 5'(PIXEL_W - 1)) begin
        bit_cnt_d     = '0;
        pixel_valid_d = 1'b1;
        pixel_data_d  = shift_d;
        pixel_index_d = pix_cnt_q;
        // pix_cnt only advances while a slot is free, so it saturates at LENGTH
        if (pix_cnt_q < LEN_C) begin
          for (int k = 0; k < LENGTH; k++) begin
            if (int'(pix_cnt_q) == k) stage_d[k] = shift_d;
          end
          pix_cnt_d = pix_cnt_q + 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end else if (latch) begin
      receiving_d = 1'b0;
      if (bit_cnt_q != '0) begin
        frame_error_d = 1'b1;
      end else if (pix_cnt_q != '0) begin
        frame_done_d = 1'b1;
        for (int k = 0; k < LENGTH; k++) strip_d[k*PIXEL_W +: PIXEL_W] = stage_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      pix_cnt_q     <= '0;
      for (int k = 0; k < LENGTH; k++) stage_q[k] <= '0;
      strip_q       <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= '0;
      receiving_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      stage_q       <= stage_d;
      strip_q       <= strip_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_index_q <= pixel_index_d;
      receiving_q   <= receiving_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      overflow_q    <= overflow_d;
    end
  end

  assign strip       = strip_q;
  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_index = pixel_index_q;
  assign receiving   = receiving_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign overflow    = overflow_q;

endmodule
